vedic_mul_pipe: RTL and testbench

//  Parametrised, pipelined Urdhva-Tiryagbhyam (vedic) multiplier; next generation of the 4x4 combinational vedic core.

---
 rtl/vedic_mul_pipe.sv | 146 ++++++++++++++
 tb/tb_vedic_mul_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: S1 sign/magnitude, S2 recursive vedic
// sub-products, S3 recombination and sign restore. Whole pipe stalls on output backpressure.

module vedic_core #(
  parameter int W = 2
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  if (W == 2) begin : g_leaf
    logic w_x;
    logic w_y;
    logic w_hh;
    logic w_c;
    // 2x2 leaf: the two cross terms meet in a half adder whose carry ripples into the high bit.
    assign w_x  = i_a[1] & i_b[0];
    assign w_y  = i_a[0] & i_b[1];
    assign w_hh = i_a[1] & i_b[1];
    assign w_c  = w_x & w_y;
    assign o_p  = {w_hh & w_c, w_hh ^ w_c, w_x ^ w_y, i_a[0] & i_b[0]};
  end else begin : g_rec
    localparam int H = W / 2;
    logic [W-1:0] w_hh;
    logic [W-1:0] w_hl;
    logic [W-1:0] w_lh;
    logic [W-1:0] w_ll;
    logic [W:0]   w_mid;

    vedic_core #(.W(H)) u_hh (.i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_p(w_hh));
    vedic_core #(.W(H)) u_hl (.i_a(i_a[W-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
    vedic_core #(.W(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[W-1:H]), .o_p(w_lh));
    vedic_core #(.W(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));

    assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
    assign o_p   = {w_hh, {W{1'b0}}}
                 + {{(H-1){1'b0}}, w_mid, {H{1'b0}}}
                 + {{W{1'b0}}, w_ll};
  end
endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mul_1,
  input  logic [WIDTH-1:0]   mul_2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);
  localparam int H   = WIDTH / 2;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("vedic_mul_pipe: WIDTH must be a power of two and >= 4");
  end

  logic               r_v1;
  logic               r_v2;
  logic               r_v3;
  logic               r_sign1;
  logic               r_sign2;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_hh;
  logic [WIDTH-1:0]   r_hl;
  logic [WIDTH-1:0]   r_lh;
  logic [WIDTH-1:0]   r_ll;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_stall;
  logic               w_adv;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_hh;
  logic [WIDTH-1:0]   w_hl;
  logic [WIDTH-1:0]   w_lh;
  logic [WIDTH-1:0]   w_ll;
  logic [WIDTH:0]     w_mid;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;

  assign w_stall   = r_v3 & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = w_adv;
  assign out_valid = r_v3;
  assign product   = r_prod;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly the magnitude wanted.
  assign w_abs_a = (is_signed & mul_1[MSB]) ? -mul_1 : mul_1;
  assign w_abs_b = (is_signed & mul_2[MSB]) ? -mul_2 : mul_2;

  vedic_core #(.W(H)) u_hh (.i_a(r_ma[WIDTH-1:H]), .i_b(r_mb[WIDTH-1:H]), .o_p(w_hh));
  vedic_core #(.W(H)) u_hl (.i_a(r_ma[WIDTH-1:H]), .i_b(r_mb[H-1:0]),     .o_p(w_hl));
  vedic_core #(.W(H)) u_lh (.i_a(r_ma[H-1:0]),     .i_b(r_mb[WIDTH-1:H]), .o_p(w_lh));
  vedic_core #(.W(H)) u_ll (.i_a(r_ma[H-1:0]),     .i_b(r_mb[H-1:0]),     .o_p(w_ll));

  assign w_mid  = {1'b0, r_hl} + {1'b0, r_lh};
  assign w_sum  = {r_hh, {WIDTH{1'b0}}}
                + {{(H-1){1'b0}}, w_mid, {H{1'b0}}}
                + {{WIDTH{1'b0}}, r_ll};
  assign w_prod = r_sign2 ? (~w_sum + 1'b1) : w_sum;

  // NOTE: datapath registers are reset too, so product reads 0 (never X) straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_sign1 <= 1'b0;
      r_sign2 <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_hh    <= '0;
      r_hl    <= '0;
      r_lh    <= '0;
      r_ll    <= '0;
      r_prod  <= '0;
    end else if (w_adv) begin
      // NOTE: non-blocking updates let every stage read its predecessor's pre-edge value.
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_sign1 <= is_signed & (mul_1[MSB] ^ mul_2[MSB]);
        r_ma    <= w_abs_a;
        r_mb    <= w_abs_b;
      end
      if (r_v1) begin
        r_sign2 <= r_sign1;
        r_hh    <= w_hh;
        r_hl    <= w_hl;
        r_lh    <= w_lh;
        r_ll    <= w_ll;
      end
      if (r_v2) begin
        r_prod <= w_prod;
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed checks of vedic_mul_pipe at WIDTH 4/8/16 plus a random 16-bit stream
// against a reference multiply.

module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       iv4 = 1'b0, s4 = 1'b0, or4 = 1'b1;
  logic       ir4, ov4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;

  logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  logic        iv16 = 1'b0, s16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;

  vedic_mul_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .mul_1(a4), .mul_2(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .product(p4));

  vedic_mul_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .mul_1(a8), .mul_2(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .product(p8));

  vedic_mul_pipe #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .mul_1(a16), .mul_2(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .product(p16));

  logic [3:0] t1a [7] = '{4'd1, 4'd8, 4'd8, 4'd10, 4'd3, 4'd3, 4'd15};
  logic [3:0] t1b [7] = '{4'd4, 4'd4, 4'd12, 4'd12, 4'd7, 4'd15, 4'd15};
  logic [7:0] t1e [7] = '{8'd4, 8'd32, 8'd96, 8'd120, 8'd21, 8'd45, 8'd225};

  logic [15:0] q8[$];
  logic [15:0] e8[$];
  logic [31:0] sb16[$];
  int          got16 = 0;
  localparam int N16 = 3000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        ua;
    logic [31:0]        ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {16'h0, a};
    ub = {16'h0, b};
    return s ? 32'(sa * sb) : ua * ub;
  endfunction

  // Products consumed by the 8-bit and 16-bit DUTs, sampled half a cycle before the pop edge.
  always @(negedge clk) if (ov8 && or8) q8.push_back(p8);

  always @(negedge clk) begin
    if (ov16 && or16) begin
      if (sb16.size() == 0) check("T6 spurious output", 32'(sb16.size()), 32'd1);
      else begin
        check("T6 product", p16, sb16.pop_front());
        got16++;
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
    bit acc = 1'b0;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    if (!acc) check("send8 accepted", 32'(acc), 32'd1);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit acc = 1'b0;
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = ir16;
      if (acc) sb16.push_back(model16(a, b, s));
      @(posedge clk);
      #1;
    end
    iv16 = 1'b0;
    if (!acc) check("send16 accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain_check8(input string tag);
    repeat (8) @(posedge clk);
    #1;
    check({tag, " count"}, 32'(q8.size()), 32'(e8.size()));
    while (q8.size() > 0 && e8.size() > 0) check(tag, q8.pop_front(), e8.pop_front());
    q8.delete();
    e8.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid8", ov8, 1'b0);
    check("reset product8", p8, 16'h0);
    check("reset in_ready8", ir8, 1'b1);
    check("reset out_valid4", ov4, 1'b0);
    check("reset product4", p4, 8'h0);
    check("reset product16", p16, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: WIDTH=4 back-to-back, exact cycle timing
    a4 = t1a[0]; b4 = t1b[0]; iv4 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (e < 7) begin
        a4 = t1a[e];
        b4 = t1b[e];
      end else iv4 = 1'b0;
      if (e < 3) check("T1 out_valid early", ov4, 1'b0);
      else if (e <= 9) begin
        check("T1 out_valid", ov4, 1'b1);
        check("T1 product", p4, t1e[e-3]);
      end else begin
        check("T1 out_valid drained", ov4, 1'b0);
        check("T1 product held", p4, 8'd225);
      end
    end

    // T2: WIDTH=8 signed corners
    e8.push_back(16'h4000); send8(8'h80, 8'h80, 1'b1);
    e8.push_back(16'hFF81); send8(8'hFF, 8'h7F, 1'b1);
    e8.push_back(16'h0000); send8(8'h00, 8'hFB, 1'b1);
    e8.push_back(16'd16129); send8(8'h7F, 8'h7F, 1'b1);
    drain_check8("T2");

    // T3: mode tracked per beat
    e8.push_back(16'd65025); send8(8'hFF, 8'hFF, 1'b0);
    e8.push_back(16'd1);     send8(8'hFF, 8'hFF, 1'b1);
    drain_check8("T3");

    // T4: four-cycle backpressure mid-stream
    e8.push_back(16'd15);
    e8.push_back(16'd400);
    e8.push_back(16'hFFEB);
    e8.push_back(16'd10000);
    e8.push_back(16'hC080);
    fork
      begin
        send8(8'd3, 8'd5, 1'b0);
        send8(8'd200, 8'd2, 1'b0);
        send8(8'hFD, 8'd7, 1'b1);
        send8(8'd100, 8'd100, 1'b0);
        send8(8'h80, 8'h7F, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        or8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("T4 in_ready stalled", ir8, 1'b0);
          check("T4 out_valid held", ov8, 1'b1);
          check("T4 product held", p8, 16'd400);
        end
        @(posedge clk);
        #1;
        or8 = 1'b1;
      end
    join
    drain_check8("T4");

    // T5: reset with three ops in flight
    send8(8'd9, 8'd9, 1'b0);
    send8(8'd10, 8'd10, 1'b0);
    send8(8'd11, 8'd11, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("T5 out_valid in reset", ov8, 1'b0);
    check("T5 product in reset", p8, 16'h0);
    check("T5 in_ready in reset", ir8, 1'b1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("T5 no stale output", 32'(q8.size()), 32'd0);
    check("T5 out_valid idle", ov8, 1'b0);
    send8(8'd7, 8'd6, 1'b0);
    check("T5 latency edge1", ov8, 1'b0);
    @(posedge clk);
    #1;
    check("T5 latency edge2", ov8, 1'b0);
    @(posedge clk);
    #1;
    check("T5 latency edge3", ov8, 1'b1);
    check("T5 product", p8, 16'd42);
    q8.delete();

    // T6: WIDTH=16 random stream with random backpressure
    fork
      begin
        for (int i = 0; i < N16; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      begin
        int cyc = 0;
        while (got16 < N16 && cyc < 40000) begin
          @(posedge clk);
          #1;
          or16 = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        or16 = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("T6 delivered count", 32'(got16), 32'(N16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
